// File: rtl/fsm_updown_counter_param.sv
// Parametrised up/down counter with wrap, saturate, ping-pong and hold modes.
// Optional registered Gray-coded output when FSM_GRAY_OUT_EN is defined.
//
//   state | meaning
//   ------+-----------------------------------------------
//   UP    | counting towards MAX_COUNT (dir = 1)
//   DOWN  | counting towards 0 (dir = 0)
module fsm_updown_counter_param #(
    parameter int WIDTH     = 3,
    parameter int MAX_COUNT = 7,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic             dir,
    output logic             wrap,
    output logic             at_max,
    output logic             at_min
`ifdef FSM_GRAY_OUT_EN
    ,
    output logic [WIDTH-1:0] out_gray
`endif
);

    typedef enum logic {
        DOWN = 1'b0,
        UP   = 1'b1
    } dir_t;

    localparam logic [1:0] MODE_WRAP = 2'b00;
    localparam logic [1:0] MODE_SAT  = 2'b01;
    localparam logic [1:0] MODE_PING = 2'b10;
    localparam logic [1:0] MODE_HOLD = 2'b11;

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

    dir_t             state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             wrap_q, wrap_d;
    logic             is_max, is_min;

    assign is_max = (out_q == MAX_V);
    assign is_min = (out_q == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= UP;
            out_q   <= RST_V;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            wrap_q  <= wrap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        wrap_d  = 1'b0;
        if (load) begin
            out_d = (load_val > MAX_V) ? MAX_V : load_val;
        end else begin
            // Outside ping-pong the direction register tracks the request even when idle.
            if (mode != MODE_PING) begin
                state_d = up ? UP : DOWN;
            end
            if (en) begin
                case (mode)
                    MODE_WRAP: begin
                        if (up) begin
                            if (is_max) begin
                                out_d  = '0;
                                wrap_d = 1'b1;
                            end else begin
                                out_d = out_q + ONE;
                            end
                        end else begin
                            if (is_min) begin
                                out_d  = MAX_V;
                                wrap_d = 1'b1;
                            end else begin
                                out_d = out_q - ONE;
                            end
                        end
                    end
                    MODE_SAT: begin
                        if (up) begin
                            out_d = is_max ? MAX_V : out_q + ONE;
                        end else begin
                            out_d = is_min ? '0 : out_q - ONE;
                        end
                    end
                    MODE_PING: begin
                        if (state_q == UP) begin
                            if (is_max) begin
                                state_d = DOWN;
                                out_d   = MAX_V - ONE;
                                wrap_d  = 1'b1;
                            end else begin
                                out_d = out_q + ONE;
                            end
                        end else begin
                            if (is_min) begin
                                state_d = UP;
                                out_d   = ONE;
                                wrap_d  = 1'b1;
                            end else begin
                                out_d = out_q - ONE;
                            end
                        end
                    end
                    MODE_HOLD: begin
                        out_d = out_q;
                    end
                    default: begin
                        out_d = out_q;
                    end
                endcase
            end
        end
    end

    assign out    = out_q;
    assign dir    = (state_q == UP);
    assign wrap   = wrap_q;
    assign at_max = is_max;
    assign at_min = is_min;

`ifdef FSM_GRAY_OUT_EN
    logic [WIDTH-1:0] gray_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            gray_q <= RST_V ^ (RST_V >> 1);
        end else begin
            gray_q <= out_d ^ (out_d >> 1);
        end
    end

    assign out_gray = gray_q;
`endif

endmodule

// File: tb/tb_fsm_updown_counter_param.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, a monitor pops and compares each cycle.
module tb_fsm_updown_counter_param;

    logic       clk = 1'b0;
    logic       reset, en, up, load;
    logic [1:0] mode;
    logic [2:0] load_val;
    logic [2:0] out;
    logic       dir, wrap, at_max, at_min;

    logic       r7, en7;
    logic [2:0] out7;
    logic       dir7, wrap7, at_max7, at_min7;
`ifdef FSM_GRAY_OUT_EN
    logic [2:0] out_gray5, out_gray7, prev_g;
    logic       have_prev = 1'b0;
`endif

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [2:0] o;
        logic       d;
        logic       w;
    } exp_t;

    typedef struct {
        logic [2:0] o;
        logic [2:0] g;
        logic       w;
    } exp7_t;

    exp_t  q[$];
    exp7_t q7[$];
    exp_t  e;
    exp7_t e7;

    always #5 clk = ~clk;

    fsm_updown_counter_param #(.WIDTH(3), .MAX_COUNT(5), .RESET_VAL(0)) dut (
        .clk(clk), .reset(reset), .en(en), .up(up), .mode(mode), .load(load),
        .load_val(load_val), .out(out), .dir(dir), .wrap(wrap),
        .at_max(at_max), .at_min(at_min)
`ifdef FSM_GRAY_OUT_EN
        , .out_gray(out_gray5)
`endif
    );

    fsm_updown_counter_param #(.WIDTH(3), .MAX_COUNT(7), .RESET_VAL(0)) dut7 (
        .clk(clk), .reset(r7), .en(en7), .up(1'b1), .mode(2'b00), .load(1'b0),
        .load_val(3'd0), .out(out7), .dir(dir7), .wrap(wrap7),
        .at_max(at_max7), .at_min(at_min7)
`ifdef FSM_GRAY_OUT_EN
        , .out_gray(out_gray7)
`endif
    );

    task automatic cmp(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic ld, input logic e_in, input logic u,
                        input logic [1:0] md, input logic [2:0] lv,
                        input logic [2:0] eo, input logic ed, input logic ew);
        exp_t x;
        @(negedge clk);
        reset = r; load = ld; en = e_in; up = u; mode = md; load_val = lv;
        x.o = eo; x.d = ed; x.w = ew;
        q.push_back(x);
    endtask

    task automatic step7(input logic r, input logic [2:0] eo, input logic [2:0] eg, input logic ew);
        exp7_t x;
        @(negedge clk);
        r7 = r; en7 = 1'b1;
        x.o = eo; x.g = eg; x.w = ew;
        q7.push_back(x);
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            cmp("out", int'(out), int'(e.o));
            cmp("dir", int'(dir), int'(e.d));
            cmp("wrap", int'(wrap), int'(e.w));
            cmp("at_max", int'(at_max), int'(e.o == 3'd5));
            cmp("at_min", int'(at_min), int'(e.o == 3'd0));
        end
        if (q7.size() > 0) begin
            e7 = q7.pop_front();
            cmp("out7", int'(out7), int'(e7.o));
            cmp("wrap7", int'(wrap7), int'(e7.w));
            cmp("at_max7", int'(at_max7), int'(e7.o == 3'd7));
`ifdef FSM_GRAY_OUT_EN
            cmp("gray7", int'(out_gray7), int'(e7.g));
            if (have_prev) cmp("gray_1bit", $countones(out_gray7 ^ prev_g), 1);
            prev_g    = out_gray7;
            have_prev = 1'b1;
`endif
        end
    end

    initial begin
        reset = 1'b1; en = 1'b0; up = 1'b1; mode = 2'b00; load = 1'b0; load_val = 3'd0;
        r7 = 1'b1; en7 = 1'b0;

        // reset held two cycles
        step(1, 0, 1, 1, 2'b00, 0, 0, 1, 0);
        step(1, 0, 1, 1, 2'b00, 0, 0, 1, 0);
        // wrap mode up
        step(0, 0, 1, 1, 2'b00, 0, 1, 1, 0);
        step(0, 0, 1, 1, 2'b00, 0, 2, 1, 0);
        step(0, 0, 1, 1, 2'b00, 0, 3, 1, 0);
        step(0, 0, 1, 1, 2'b00, 0, 4, 1, 0);
        step(0, 0, 1, 1, 2'b00, 0, 5, 1, 0);
        step(0, 0, 1, 1, 2'b00, 0, 0, 1, 1);
        step(0, 0, 1, 1, 2'b00, 0, 1, 1, 0);
        // wrap mode down
        step(0, 0, 1, 0, 2'b00, 0, 0, 0, 0);
        step(0, 0, 1, 0, 2'b00, 0, 5, 0, 1);
        step(0, 0, 1, 0, 2'b00, 0, 4, 0, 0);
        // saturate: load 3 (dir unchanged), then up x5
        step(0, 1, 1, 1, 2'b01, 3, 3, 0, 0);
        step(0, 0, 1, 1, 2'b01, 0, 4, 1, 0);
        step(0, 0, 1, 1, 2'b01, 0, 5, 1, 0);
        step(0, 0, 1, 1, 2'b01, 0, 5, 1, 0);
        step(0, 0, 1, 1, 2'b01, 0, 5, 1, 0);
        step(0, 0, 1, 1, 2'b01, 0, 5, 1, 0);
        // saturate down from 1
        step(0, 1, 0, 0, 2'b01, 1, 1, 1, 0);
        step(0, 0, 1, 0, 2'b01, 0, 0, 0, 0);
        step(0, 0, 1, 0, 2'b01, 0, 0, 0, 0);
        step(0, 0, 1, 0, 2'b01, 0, 0, 0, 0);
        // set dir UP, load 4, then ping-pong with up held low
        step(0, 0, 1, 1, 2'b01, 0, 1, 1, 0);
        step(0, 1, 1, 0, 2'b10, 4, 4, 1, 0);
        step(0, 0, 1, 0, 2'b10, 0, 5, 1, 0);
        step(0, 0, 1, 0, 2'b10, 0, 4, 0, 1);
        step(0, 0, 1, 0, 2'b10, 0, 3, 0, 0);
        step(0, 0, 1, 0, 2'b10, 0, 2, 0, 0);
        step(0, 0, 1, 0, 2'b10, 0, 1, 0, 0);
        step(0, 0, 1, 0, 2'b10, 0, 0, 0, 0);
        step(0, 0, 1, 0, 2'b10, 0, 1, 1, 1);
        step(0, 0, 1, 0, 2'b10, 0, 2, 1, 0);
        // enable low in ping-pong: everything holds
        step(0, 0, 0, 0, 2'b10, 0, 2, 1, 0);
        // clamped load with en high, then wrap from max
        step(0, 1, 1, 1, 2'b00, 7, 5, 1, 0);
        step(0, 0, 1, 1, 2'b00, 0, 0, 1, 1);
        // count down to 3, then reset beats load and en
        step(0, 0, 1, 0, 2'b00, 0, 5, 0, 1);
        step(0, 0, 1, 0, 2'b00, 0, 4, 0, 0);
        step(0, 0, 1, 0, 2'b00, 0, 3, 0, 0);
        step(1, 1, 1, 0, 2'b00, 2, 0, 1, 0);
        // hold mode
        step(0, 0, 1, 1, 2'b00, 0, 1, 1, 0);
        step(0, 0, 1, 1, 2'b00, 0, 2, 1, 0);
        step(0, 0, 1, 0, 2'b11, 0, 2, 0, 0);
        step(0, 0, 1, 1, 2'b11, 0, 2, 1, 0);

        // full-range counter: out and Gray sequence
        step7(1, 0, 0, 0);
        step7(0, 1, 1, 0);
        step7(0, 2, 3, 0);
        step7(0, 3, 2, 0);
        step7(0, 4, 6, 0);
        step7(0, 5, 7, 0);
        step7(0, 6, 5, 0);
        step7(0, 7, 4, 0);
        step7(0, 0, 0, 1);

        @(posedge clk);
        #3;
        cmp("queue_drained", q.size() + q7.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fsm_updown_counter_param.md
Name: fsm_updown_counter_param

Overview:
- Parametrised successor of the lab-6 3-bit up/down counter FSM.
- Generalises width and terminal value, and adds an enable and a synchronous load.
- Adds four run-time modes: wrap, saturate, ping-pong, hold.
- Adds a direction state machine plus wrap and endpoint flags. Used as the counting core for later lab exercises and as a stand-alone demo on the board.

Parameters:
- WIDTH, 3: counter width in bits.
- MAX_COUNT, 7: upper endpoint, inclusive. Must satisfy 1 <= MAX_COUNT <= 2**WIDTH-1.
- RESET_VAL, 0: value of out after reset. Must be <= MAX_COUNT.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  count enable; one step per enabled cycle.
- up  input  1  requested direction: 1 = up, 0 = down. Ignored in ping-pong mode.
- mode  input  2  00 wrap, 01 saturate, 10 ping-pong, 11 hold.
- load  input  1  synchronous load strobe.
- load_val  input  WIDTH  value to load.
- out  output  WIDTH  current count, registered.
- dir  output  1  current direction state: 1 = up, 0 = down.
- wrap  output  1  registered one-cycle pulse on wrap-around or on ping-pong reversal.
- at_max  output  1  combinational: out == MAX_COUNT.
- at_min  output  1  combinational: out == 0.

Behaviour:
- Reset (synchronous, active-high):
  - out = RESET_VAL, dir = 1 (UP), wrap = 0.
  - Reset wins over every other input.
  - Reset asserted mid-count takes effect on the next edge; no partial step.
- Priority per edge: reset > load > en. With en = 0 and no load, all registers hold and wrap = 0.
- Load:
  - out <= min(load_val, MAX_COUNT), i.e. load_val is clamped.
  - dir is unchanged, wrap = 0. Load with en = 1 performs the load only.
- Direction FSM, states UP and DOWN:
  - Modes 00/01/11: dir follows the up input every cycle (dir <= up), regardless of en.
  - Mode 10: up is ignored.
    - In UP, an enabled step at out == MAX_COUNT goes to DOWN and out becomes MAX_COUNT-1.
    - In DOWN, an enabled step at out == 0 goes to UP and out becomes 1.
    - Each such reversal sets wrap = 1 for one cycle.
- Step rules, applied when en = 1 and there is no reset or load:
  - Wrap (00):
    - Up: MAX_COUNT -> 0, else +1.
    - Down: 0 -> MAX_COUNT, else -1.
    - wrap = 1 exactly in the cycle out shows the wrapped value.
  - Saturate (01): up stops at MAX_COUNT, down stops at 0. wrap is always 0.
  - Ping-pong (10): as in the direction FSM. A non-endpoint step is +1 in UP and -1 in DOWN.
  - Hold (11): out holds, wrap = 0.
- out > MAX_COUNT is unreachable: load clamps and the step logic never exceeds MAX_COUNT.
- Mode change mid-count:
  - Takes effect on the same edge. No flush.
  - Entering ping-pong starts from the current dir value.
- Arithmetic is WIDTH bits. Comparisons are against MAX_COUNT and never rely on natural overflow, so a non-power-of-two MAX_COUNT works.
- Latency: one clock from en/load/reset to out.
- at_max and at_min are decoded from registered out, with no extra latency.

Optional Feature:
- Macro FSM_GRAY_OUT_EN.
- When defined:
  - Adds output out_gray [WIDTH-1:0], registered and equal to (out >> 1) ^ out of the same cycle.
  - Updated on the same edge as out; reset value is the Gray code of RESET_VAL.
- When undefined: the port and its logic are absent and all other behaviour is identical.

Test Plan:
- WIDTH = 3, MAX_COUNT = 5, mode = 00, up = 1, en = 1, reset held 2 cycles then released -> out sequence 0,1,2,3,4,5,0,1 with wrap = 1 only in the cycle out = 0 after 5. Then up = 0 -> 0,5,4,... with wrap = 1 at the 0 -> 5 transition.
- mode = 01, count up from 3 for 5 cycles -> 4,5,5,5,5 and wrap is never 1. Then up = 0 from 1 -> 0,0,0.
- mode = 10, start 4, dir = UP, up held at 0 -> 5,4,3,2,1,0,1,2. dir goes to 0 at the 5 -> 4 step and back to 1 at the 0 -> 1 step. wrap = 1 in the cycle out = 4 and in the cycle out = 1.
- load = 1 with load_val = 7 (MAX_COUNT = 5) and en = 1 -> out = 5, at_max = 1. Next cycle with load = 0 in mode 00, up = 1 -> out = 0, wrap = 1.
- reset = 1 asserted while out = 3 with en = 1 and load = 1 -> out = RESET_VAL (0) on that edge, dir = 1, wrap = 0.
- FSM_GRAY_OUT_EN defined, up-count 0..7 with MAX_COUNT = 7 -> out_gray = 0,1,3,2,6,7,5,4. Between any two consecutive values exactly one bit differs.
